// File: rtl/rr_grant_ctrl_pkg.sv
// Shared definitions for the round-robin grant controller: state encoding,
// hold counter width and the index-width helper.
package rr_grant_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  localparam int HOLD_W = 8;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Requester-side bus of the grant controller. master = requesters,
// slave = the arbiter.
interface rr_grant_ctrl_if #(
  parameter int N_REQ = 4
);
  import rr_grant_ctrl_pkg::*;

  localparam int W = id_width(N_REQ);

  logic [N_REQ-1:0] req;
  logic             rel;
  logic [N_REQ-1:0] gnt;
  logic [W-1:0]     gnt_id;
  logic             busy;
  logic             timeout;

  modport master (output req, rel, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, rel, output gnt, gnt_id, busy, timeout);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from
// ptr, modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int W     = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic             valid,
  output logic [W-1:0]     winner
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot;
  logic               found;

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  assign req_dbl = {req, req};
  assign rot     = N_REQ'(req_dbl >> ptr);
  assign valid   = |req;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        winner = W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin single-owner grant controller with a one-cycle gap between owners.
// Define RR_GRANT_HOLD_TIMEOUT_EN to revoke ownership after MAX_HOLD cycles.
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input logic            clk,
  input logic            rst,
  rr_grant_ctrl_if.slave bus
);

  localparam int W = id_width(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_grant_ctrl: parameter out of range");
  end

  state_t           state_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [W-1:0]     gnt_id_reg;
  logic [W-1:0]     ptr_reg;
  logic             busy_reg;
  logic             pick_valid;
  logic [W-1:0]     pick_id;
  logic [W-1:0]     ptr_next;
  logic             owner_drop;
  logic             hold_expired;
  logic             exit_own;
  logic             forced;

  rr_pick #(.N_REQ(N_REQ), .W(W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .winner (pick_id)
  );

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              timeout_reg;
  assign hold_expired = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign bus.timeout  = timeout_reg;
`else
  assign hold_expired = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  assign owner_drop = !bus.req[gnt_id_reg];
  assign exit_own   = bus.rel | owner_drop | hold_expired;
  // A voluntary exit wins over a coincident hold expiry.
  assign forced     = hold_expired & !bus.rel & !owner_drop;
  assign ptr_next   = (gnt_id_reg == W'(N_REQ - 1)) ? '0 : gnt_id_reg + W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      ptr_reg     <= '0;
      busy_reg    <= 1'b0;
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_GAP: begin
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
          timeout_reg  <= 1'b0;
          hold_cnt_reg <= '0;
`endif
          if (pick_valid) begin
            state_reg  <= ST_OWN;
            gnt_reg    <= N_REQ'(1) << pick_id;
            gnt_id_reg <= pick_id;
            busy_reg   <= 1'b1;
          end else begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            busy_reg   <= 1'b0;
          end
        end
        ST_OWN: begin
          if (exit_own) begin
            state_reg  <= ST_GAP;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            busy_reg   <= 1'b0;
            ptr_reg    <= ptr_next;
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
            timeout_reg  <= forced;
            hold_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
`endif
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          gnt_reg    <= '0;
          gnt_id_reg <= '0;
          busy_reg   <= 1'b0;
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
          timeout_reg  <= 1'b0;
          hold_cnt_reg <= '0;
`endif
        end
      endcase
    end
  end

`ifndef RR_GRANT_HOLD_TIMEOUT_EN
  logic unused_forced;
  assign unused_forced = forced;
`endif

  assign bus.gnt    = gnt_reg;
  assign bus.gnt_id = gnt_id_reg;
  assign bus.busy   = busy_reg;

endmodule
